linear_layer_start_fifo_ctrl: RTL

LINEAR_LAYER_START_FIFO_CTRL -- requirements
Module: linear_layer_start_fifo_ctrl

---
 rtl/linear_layer_start_fifo_ctrl.sv | 127 ++++++++++++
 1 files changed

// File: rtl/linear_layer_start_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// linear_layer_start_fifo_ctrl
//   First-word fall-through FIFO controller built on shift-register storage.
//   New tokens enter at entry[0] and ripple upward on each accepted write.
//   The oldest token is always found at entry[count-1].
//
// Parameters
//   DATA_WIDTH : width of each stored token
//   ADDR_WIDTH : index width, DEPTH <= 2**ADDR_WIDTH
//   DEPTH      : maximum number of stored tokens (>= 1)
//
// Ports
//   clk         in   single clock, rising edge
//   reset       in   asynchronous active-high reset
//   if_write_ce in   write-side clock enable
//   if_write    in   producer write request
//   if_din      in   producer token
//   if_full_n   out  high when a write can be accepted (registered)
//   if_read_ce  in   read-side clock enable
//   if_read     in   consumer read request
//   if_dout     out  oldest stored token (valid while if_empty_n is high)
//   if_empty_n  out  high when if_dout holds a valid token (registered)
//   usedw       out  current occupancy 0..DEPTH
//   err_ovf     out  sticky: write attempted while full
//   err_udf     out  sticky: read attempted while empty
// -----------------------------------------------------------------------------
module linear_layer_start_fifo_ctrl #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 1,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_full_n,
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_empty_n,
  output logic [ADDR_WIDTH:0]   usedw,
  output logic                  err_ovf,
  output logic                  err_udf
);

  localparam logic [ADDR_WIDTH:0] LP_DEPTH = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] LP_ZERO  = {(ADDR_WIDTH+1){1'b0}};
  localparam logic [ADDR_WIDTH:0] LP_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_empty_n;
  logic                  r_full_n;
  logic                  r_err_ovf;
  logic                  r_err_udf;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_ovf_evt;
  logic                  w_udf_evt;
  logic [ADDR_WIDTH:0]   w_count_nxt;
  logic [DATA_WIDTH-1:0] w_dout;

  // Handshake qualification uses the registered flags, so a pop in the same
  // cycle never frees room for a push while full (producer retries next cycle).
  assign w_push    = if_write & if_write_ce & r_full_n;
  assign w_pop     = if_read  & if_read_ce  & r_empty_n;
  assign w_ovf_evt = if_write & if_write_ce & ~r_full_n;
  assign w_udf_evt = if_read  & if_read_ce  & ~r_empty_n;

  // Next occupancy: push and pop together leave the count unchanged.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + LP_ONE;
      2'b01:   w_count_nxt = r_count - LP_ONE;
      default: w_count_nxt = r_count;
    endcase
  end

  // Control state: occupancy, registered status flags and sticky error flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count   <= LP_ZERO;
      r_empty_n <= 1'b0;
      r_full_n  <= 1'b1;
      r_err_ovf <= 1'b0;
      r_err_udf <= 1'b0;
    end else begin
      r_count   <= w_count_nxt;
      // Flags are derived from the next count so they line up with usedw.
      r_empty_n <= (w_count_nxt != LP_ZERO);
      r_full_n  <= (w_count_nxt != LP_DEPTH);
      r_err_ovf <= r_err_ovf | w_ovf_evt;
      r_err_udf <= r_err_udf | w_udf_evt;
    end
  end

  // Shift storage, intentionally not reset: a push loads entry[0] and moves
  // every entry one slot toward the read end.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[0] <= if_din;
      for (int i = 1; i < DEPTH; i++) begin
        r_mem[i] <= r_mem[i-1];
      end
    end
  end

  // Read mux: select entry[count-1]; output is zero when empty (don't-care).
  always_comb begin
    w_dout = {DATA_WIDTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      w_dout = w_dout |
               ({DATA_WIDTH{r_count == (ADDR_WIDTH+1)'(i + 1)}} & r_mem[i]);
    end
  end

  assign if_dout    = w_dout;
  assign if_empty_n = r_empty_n;
  assign if_full_n  = r_full_n;
  assign usedw      = r_count;
  assign err_ovf    = r_err_ovf;
  assign err_udf    = r_err_udf;

endmodule
